// File: rtl/projectile_pool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : projectile_pool
// Brief    : Multi-slot player projectile manager. Spawns projectiles above
//            the player on a fire-button rising edge, moves them upward once
//            per frame tick and retires them on collision or when they leave
//            the top of the screen. At most one fire request is queued.
// Options  : PROJ_COOLDOWN_EN - when defined, a shot-to-shot cooldown counted
//            in move_tick units gates spawning.
// Revision : 1.0 - initial multi-slot version
// ============================================================================
module projectile_pool #(
  parameter int NUM_PROJ    = 4,
  parameter int SPEED       = 4,
  parameter int SPAWN_X_OFF = 30,
  parameter int SPAWN_Y     = 448,
  parameter int COOLDOWN    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            move_tick_i,
  input  logic                            shoot_i,
  input  logic [9:0]                      playerx_i,
  input  logic [NUM_PROJ-1:0]             hit_i,
  output logic [NUM_PROJ*10-1:0]          proj_x_o,
  output logic [NUM_PROJ*10-1:0]          proj_y_o,
  output logic [NUM_PROJ-1:0]             exists_o,
  output logic                            fire_ack_o,
  output logic [$clog2(NUM_PROJ+1)-1:0]   active_count_o
);

  localparam int          CNT_W     = $clog2(NUM_PROJ + 1);
  localparam logic [9:0]  c_speed   = 10'(SPEED);
  localparam logic [9:0]  c_spawn_y = 10'(SPAWN_Y);
  localparam logic [10:0] c_x_off   = 11'(SPAWN_X_OFF);

  // Registered state
  logic                shoot_q;
  logic                pending_q, pending_d;
  logic [NUM_PROJ-1:0] exists_q, exists_d;
  logic [9:0]          x_q [NUM_PROJ];
  logic [9:0]          x_d [NUM_PROJ];
  logic [9:0]          y_q [NUM_PROJ];
  logic [9:0]          y_d [NUM_PROJ];
  logic                fire_ack_q;
  logic [CNT_W-1:0]    count_q, count_d;

  // Combinational helpers
  logic                w_shoot_edge;
  logic                w_req;
  logic [NUM_PROJ-1:0] w_free;
  logic [NUM_PROJ-1:0] w_spawn_sel;
  logic                w_spawn;
  logic                w_cd_zero;
  logic [10:0]         w_x_sum;
  logic [9:0]          w_spawn_x;

  assign w_shoot_edge = shoot_i & ~shoot_q;
  assign w_req        = w_shoot_edge | pending_q;

  // Only slots empty at cycle start are candidates, so a slot being retired
  // this cycle can never be reused until the following edge.
  assign w_free       = ~exists_q;
  // Isolate the lowest set bit: lowest-index free slot as a one-hot vector.
  assign w_spawn_sel  = w_free & (~w_free + NUM_PROJ'(1));
  assign w_spawn      = w_req & (|w_free) & w_cd_zero;

  // Spawn x is computed one bit wider so a right-edge player saturates at 1023.
  assign w_x_sum      = {1'b0, playerx_i} + c_x_off;
  assign w_spawn_x    = w_x_sum[10] ? 10'h3FF : w_x_sum[9:0];

  // A request that cannot be served now is held until a spawn consumes it.
  assign pending_d    = w_req & ~w_spawn;

`ifdef PROJ_COOLDOWN_EN
  localparam int              CD_W       = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] c_cooldown = CD_W'(COOLDOWN);

  logic [CD_W-1:0] cd_q, cd_d;

  assign w_cd_zero = (cd_q == '0);

  // Cooldown reloads on every spawn and counts frame ticks down to zero.
  always_comb begin
    cd_d = cd_q;
    if (w_spawn) begin
      cd_d = c_cooldown;
    end else if (move_tick_i && (cd_q != '0)) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  // Cooldown counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_q <= '0;
    end else begin
      cd_q <= cd_d;
    end
  end
`else
  logic unused_cooldown;

  assign w_cd_zero       = 1'b1;
  assign unused_cooldown = (COOLDOWN != 0);
`endif

  // Per-slot next state: spawn load, else hit retirement, else upward motion.
  always_comb begin
    exists_d = exists_q;
    for (int i = 0; i < NUM_PROJ; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (w_spawn && w_spawn_sel[i]) begin
        x_d[i]      = w_spawn_x;
        y_d[i]      = c_spawn_y;
        exists_d[i] = 1'b1;
      end else if (exists_q[i]) begin
        if (hit_i[i]) begin
          exists_d[i] = 1'b0;
        end else if (move_tick_i) begin
          if (y_q[i] < c_speed) begin
            exists_d[i] = 1'b0;
          end else begin
            y_d[i] = y_q[i] - c_speed;
          end
        end
      end
    end
  end

  // Population count of the slots live at cycle start.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      count_d = count_d + CNT_W'(exists_q[i]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shoot_q    <= 1'b0;
      pending_q  <= 1'b0;
      exists_q   <= '0;
      fire_ack_q <= 1'b0;
      count_q    <= '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      shoot_q    <= shoot_i;
      pending_q  <= pending_d;
      exists_q   <= exists_d;
      fire_ack_q <= w_spawn;
      count_q    <= count_d;
      for (int i = 0; i < NUM_PROJ; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_PROJ; g++) begin : g_pack
      assign proj_x_o[10*g +: 10] = x_q[g];
      assign proj_y_o[10*g +: 10] = y_q[g];
    end
  endgenerate

  assign exists_o       = exists_q;
  assign fire_ack_o     = fire_ack_q;
  assign active_count_o = count_q;

endmodule
`default_nettype wire
